// File: rtl/comp_acc_pkg.sv
// rtl/comp_acc_pkg.sv - shared op encodings, FSM states and sizing helper for comp_acc_display
package comp_acc_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  // Smallest counter width (at least 1) able to count n distinct steps.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble converter, one shift/add-3 iteration per cycle
module bin2bcd_seq
  import comp_acc_pkg::*;
#(
  parameter int ACC_WIDTH = 8,
  parameter int DIGITS    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ACC_WIDTH-1:0]  mag,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = cnt_width(ACC_WIDTH);
  localparam int SW = 4 * DIGITS;

  logic [ACC_WIDTH-1:0]    shreg;
  logic [SW-1:0]           scratch;
  logic [SW-1:0]           adj;
  logic [CW-1:0]           cnt;
  logic [SW+ACC_WIDTH-1:0] pair_next;

  always_comb begin
    adj = scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
    end
    pair_next = {adj, shreg} << 1;
  end

  // done marks the cycle of the final iteration so the caller can retire on the same edge.
  assign done = busy && (cnt == CW'(ACC_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      cnt     <= '0;
      shreg   <= '0;
      scratch <= '0;
      bcd     <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      cnt     <= '0;
      shreg   <= mag;
      scratch <= '0;
    end else if (busy) begin
      {scratch, shreg} <= pair_next;
      cnt              <= cnt + 1'b1;
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
        bcd  <= pair_next[SW+ACC_WIDTH-1 -: SW];
      end
    end
  end

endmodule

// File: rtl/comp_acc_display.sv
// rtl/comp_acc_display.sv - signed accumulator with handshake and sign/BCD display conversion
module comp_acc_display
  import comp_acc_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = 8,
  parameter int DIGITS     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            in_op,
  output logic [ACC_WIDTH-1:0]  acc_out,
  output logic                  ovf,
  output logic                  neg,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  disp_valid
);

  localparam int M = ACC_WIDTH - 1;

  state_t               state;
  logic                 conv_busy;
  logic                 conv_done;
  logic                 hs;
  logic [ACC_WIDTH-1:0] ext;
  logic [ACC_WIDTH-1:0] neg_ext;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [ACC_WIDTH-1:0] mag;
  logic                 ovf_next;

  assign in_ready = (state == S_IDLE) && !conv_busy;
  assign hs       = in_valid && in_ready;

  always_comb begin
    ext      = ACC_WIDTH'($signed(in_data));
    neg_ext  = -ext;
    acc_next = acc_out;
    ovf_next = ovf;
    case (in_op)
      OP_LOAD: begin
        acc_next = ext;
        ovf_next = 1'b0;
      end
      OP_ADD: begin
        acc_next = acc_out + ext;
        if (acc_out[M] == ext[M] && acc_next[M] != acc_out[M]) ovf_next = 1'b1;
      end
      OP_SUB: begin
        // Subtraction is treated as adding the negated operand for the overflow rule.
        acc_next = acc_out + neg_ext;
        if (acc_out[M] == neg_ext[M] && acc_next[M] != acc_out[M]) ovf_next = 1'b1;
      end
      default: begin
        acc_next = '0;
        ovf_next = 1'b0;
      end
    endcase
    // The most negative value maps to 2**(ACC_WIDTH-1), which still fits unsigned.
    mag = acc_next[M] ? -acc_next : acc_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      acc_out    <= '0;
      ovf        <= 1'b0;
      neg        <= 1'b0;
      disp_valid <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (hs) begin
            acc_out    <= acc_next;
            ovf        <= ovf_next;
            neg        <= acc_next[M];
            disp_valid <= 1'b0;
            state      <= S_CONV;
          end
        end
        S_CONV: begin
          if (conv_done) begin
            disp_valid <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  bin2bcd_seq #(
    .ACC_WIDTH (ACC_WIDTH),
    .DIGITS    (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (hs),
    .mag   (mag),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

endmodule

// File: tb/tb_comp_acc_display.sv
// tb/tb_comp_acc_display.sv - randomized bench with behavioural accumulator/display model
module tb_comp_acc_display;

  localparam int DW = 4;
  localparam int AW = 8;
  localparam int DG = 3;
  localparam int MASK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [1:0]    in_op;
  logic [AW-1:0] acc_out;
  logic          ovf;
  logic          neg;
  logic [4*DG-1:0] bcd;
  logic          disp_valid;

  int n_cmp = 0;
  int n_fail = 0;

  // Model state: signed accumulator value, sticky flag, cycles of conversion left, displayed value.
  int m_acc = 0;
  int m_ovf = 0;
  int m_busy = 0;
  int m_disp = 0;
  bit m_ok = 0;

  always #5 clk = ~clk;

  comp_acc_display #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .DIGITS(DG)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_op      (in_op),
    .acc_out    (acc_out),
    .ovf        (ovf),
    .neg        (neg),
    .bcd        (bcd),
    .disp_valid (disp_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4*DG-1:0] to_bcd(input int v);
    logic [4*DG-1:0] r;
    int m;
    m = (v < 0) ? -v : v;
    r = '0;
    for (int d = 0; d < DG; d++) begin
      r[4*d +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic int wrap(input int v);
    int r;
    r = v & MASK;
    if (r >= (1 << (AW - 1))) r = r - (1 << AW);
    return r;
  endfunction

  // Compare against the model, then advance it using the inputs the next edge will sample.
  initial begin
    int ext, r;
    forever begin
      @(negedge clk);
      if (m_ok) begin
        chk("acc_out", acc_out, m_acc & MASK);
        chk("ovf", ovf, m_ovf);
        chk("neg", neg, (m_acc < 0));
        chk("in_ready", in_ready, (m_busy == 0));
        chk("disp_valid", disp_valid, (m_busy == 0));
        chk("bcd", bcd, to_bcd(m_disp));
      end
      if (rst) begin
        m_acc = 0; m_ovf = 0; m_busy = 0; m_disp = 0; m_ok = 1;
      end else if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) m_disp = m_acc;
      end else if (in_valid) begin
        ext = int'($signed(in_data));
        case (in_op)
          2'b00: begin m_acc = ext; m_ovf = 0; end
          2'b01, 2'b10: begin
            r = (in_op == 2'b01) ? m_acc + ext : m_acc - ext;
            if (r > (1 << (AW - 1)) - 1 || r < -(1 << (AW - 1))) m_ovf = 1;
            m_acc = wrap(r);
          end
          default: begin m_acc = 0; m_ovf = 0; end
        endcase
        m_busy = AW;
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [DW-1:0] d);
    int k;
    k = 0;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 100) chk("send_timeout", 1, 0);
    in_valid = 1'b1; in_op = op; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Waits for the conversion to finish while throwing ignored traffic at the block.
  task automatic wait_idle(output int n);
    n = 0;
    while (!in_ready && n < 100) begin
      in_valid = 1'($urandom);
      in_op = 2'($urandom);
      in_data = DW'($urandom);
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    if (n >= 100) chk("idle_timeout", 1, 0);
  endtask

  task automatic run(input logic [1:0] op, input logic [DW-1:0] d);
    int n;
    send(op, d);
    wait_idle(n);
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_acc", acc_out, 8'h00);
    chk("rst_bcd", bcd, 12'h000);
    chk("rst_neg", neg, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_dv", disp_valid, 1);
    chk("rst_rdy", in_ready, 1);

    send(2'b00, 4'b0101);
    chk("ld5_acc_t1", acc_out, 8'h05);
    wait_idle(n);
    chk("ld5_bcd", bcd, 12'h005);
    chk("ld5_dv", disp_valid, 1);

    send(2'b00, 4'b1101);
    chk("ldm3_acc", acc_out, 8'hFD);
    chk("ldm3_neg", neg, 1);
    wait_idle(n);
    chk("ldm3_busy_cycles", n, 8);
    chk("ldm3_acc_hold", acc_out, 8'hFD);
    chk("ldm3_bcd", bcd, 12'h003);

    run(2'b00, 4'd7);
    repeat (17) run(2'b01, 4'd7);
    chk("add7_acc", acc_out, 8'h7E);
    chk("add7_bcd", bcd, 12'h126);
    chk("add7_ovf", ovf, 0);
    run(2'b01, 4'd7);
    chk("ovf_acc", acc_out, 8'h85);
    chk("ovf_neg", neg, 1);
    chk("ovf_bcd", bcd, 12'h123);
    chk("ovf_flag", ovf, 1);
    run(2'b11, 4'd0);
    chk("clr_acc", acc_out, 8'h00);
    chk("clr_ovf", ovf, 0);
    chk("clr_bcd", bcd, 12'h000);

    run(2'b00, 4'b1000);
    repeat (15) run(2'b01, 4'b1000);
    chk("min_acc", acc_out, 8'h80);
    chk("min_neg", neg, 1);
    chk("min_bcd", bcd, 12'h128);
    chk("min_ovf", ovf, 0);
    run(2'b10, 4'b1000);
    chk("subm8_acc", acc_out, 8'h88);
    chk("subm8_bcd", bcd, 12'h120);
    chk("subm8_ovf", ovf, 0);

    run(2'b11, 4'd0);
    run(2'b10, 4'b1000);
    chk("s8_acc", acc_out, 8'h08);
    chk("s8_neg", neg, 0);
    chk("s8_bcd", bcd, 12'h008);
    run(2'b10, 4'b0111);
    chk("s7_acc", acc_out, 8'h01);
    chk("s7_bcd", bcd, 12'h001);

    send(2'b00, 4'b1011);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_acc", acc_out, 8'h00);
    chk("mid_rst_bcd", bcd, 12'h000);
    chk("mid_rst_neg", neg, 0);
    chk("mid_rst_dv", disp_valid, 1);
    chk("mid_rst_rdy", in_ready, 1);
    run(2'b00, 4'd2);
    chk("after_rst_bcd", bcd, 12'h002);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end else begin
        run(2'($urandom_range(0, 9) < 2 ? 0 : $urandom_range(1, 3) == 3 && $urandom_range(0, 3) != 0
                ? $urandom_range(1, 2) : $urandom_range(1, 3)), DW'($urandom));
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
    end
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
